// File: rtl/noc_sched_pkg.sv
// noc_sched_pkg: shared FSM state type and one-hot to index helper for the packet scheduler
package noc_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_e;

    function automatic logic [31:0] onehot2idx(input logic [63:0] oh);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 64; i++)
            if (oh[i]) r |= 32'(i);
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request at or after the pointer, wrapping, as a one-hot pick
module rr_priority_pick #(
    parameter int CHANNEL_NUMBER       = 10,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
    input  logic [CHANNEL_NUMBER-1:0]       req_i,
    input  logic [CHANNEL_NUMBER_WIDTH-1:0] ptr_i,
    output logic [CHANNEL_NUMBER-1:0]       pick_o,
    output logic                            any_o
);

    // scan from farthest to nearest so the nearest requester at/after the pointer wins
    always_comb begin
        int k;
        pick_o = '0;
        for (int i = CHANNEL_NUMBER - 1; i >= 0; i--) begin
            k = (int'(ptr_i) + i) % CHANNEL_NUMBER;
            if (req_i[k]) begin
                pick_o    = '0;
                pick_o[k] = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/router_wrr_packet_scheduler.sv
// router_wrr_packet_scheduler: packet-level weighted round-robin grant with long-packet watchdog
module router_wrr_packet_scheduler
    import noc_sched_pkg::*;
#(
    parameter int CHANNEL_NUMBER       = 10,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int WEIGHT_WIDTH         = 3,
    parameter int MAX_PACKET_BEATS     = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [CHANNEL_NUMBER-1:0]              req_i,
    input  logic [CHANNEL_NUMBER*WEIGHT_WIDTH-1:0] cfg_weight_i,
    input  logic                                   beat_fire_i,
    input  logic                                   last_i,
    output logic [CHANNEL_NUMBER-1:0]              grant_o,
    output logic [CHANNEL_NUMBER_WIDTH-1:0]        grant_idx_o,
    output logic                                   grant_valid_o,
    output logic                                   err_long_pkt_o
);

    localparam int BW = $clog2(MAX_PACKET_BEATS + 1);

    sched_state_e                    state_q;
    logic [CHANNEL_NUMBER-1:0]       grant_q;
    logic [CHANNEL_NUMBER_WIDTH-1:0] idx_q;
    logic [CHANNEL_NUMBER_WIDTH-1:0] ptr_q;
    logic [WEIGHT_WIDTH-1:0]         credit_q;
    logic [BW-1:0]                   beats_q;
    logic                            err_q;

    logic [CHANNEL_NUMBER-1:0]       req_excl;
    logic [CHANNEL_NUMBER-1:0]       pick_req;
    logic [CHANNEL_NUMBER_WIDTH-1:0] pick_ptr;
    logic [CHANNEL_NUMBER_WIDTH-1:0] ptr_d;
    logic [CHANNEL_NUMBER-1:0]       pick;
    logic                            pick_any;
    logic [CHANNEL_NUMBER_WIDTH-1:0] pick_idx;
    logic [WEIGHT_WIDTH-1:0]         pick_w;
    logic [WEIGHT_WIDTH-1:0]         pick_credit;
    logic [WEIGHT_WIDTH-1:0]         credit_d;
    logic                            keep;

    // In BUSY the pick is only used at end of packet, starting just past the finished channel
    // and skipping it unless it is the sole requester.
    always_comb begin
        req_excl    = req_i & ~grant_q;
        ptr_d       = (idx_q == CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1)) ? '0 : idx_q + 1'b1;
        pick_req    = (state_q == IDLE) ? req_i : (|req_excl ? req_excl : req_i);
        pick_ptr    = (state_q == IDLE) ? ptr_q : ptr_d;
        pick_idx    = CHANNEL_NUMBER_WIDTH'(onehot2idx(64'(pick)));
        pick_w      = cfg_weight_i[int'(pick_idx) * WEIGHT_WIDTH +: WEIGHT_WIDTH];
        pick_credit = (pick_w == '0) ? WEIGHT_WIDTH'(1) : pick_w;
        credit_d    = credit_q - 1'b1;
        keep        = (credit_d != '0) && |(req_i & grant_q);
    end

    rr_priority_pick #(
        .CHANNEL_NUMBER      (CHANNEL_NUMBER),
        .CHANNEL_NUMBER_WIDTH(CHANNEL_NUMBER_WIDTH)
    ) u_pick (
        .req_i (pick_req),
        .ptr_i (pick_ptr),
        .pick_o(pick),
        .any_o (pick_any)
    );

    // grant FSM: arbitrate in IDLE, hold through the packet, re-arbitrate on the TLAST beat
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
            beats_q  <= '0;
            err_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            if (pick_any) begin
                state_q  <= BUSY;
                grant_q  <= pick;
                idx_q    <= pick_idx;
                credit_q <= pick_credit;
                beats_q  <= '0;
            end
        end else if (beat_fire_i && last_i) begin
            beats_q <= '0;
            if (keep) begin
                credit_q <= credit_d;
            end else begin
                ptr_q <= ptr_d;
                if (pick_any) begin
                    grant_q  <= pick;
                    idx_q    <= pick_idx;
                    credit_q <= pick_credit;
                end else begin
                    state_q  <= IDLE;
                    grant_q  <= '0;
                    idx_q    <= '0;
                    credit_q <= '0;
                end
            end
        end else if (beat_fire_i) begin
            if (beats_q != BW'(MAX_PACKET_BEATS)) beats_q <= beats_q + 1'b1;
            if (beats_q == BW'(MAX_PACKET_BEATS - 1)) err_q <= 1'b1;
        end
    end

    assign grant_o        = grant_q;
    assign grant_idx_o    = idx_q;
    assign grant_valid_o  = (state_q == BUSY);
    assign err_long_pkt_o = err_q;

    // a beat with no grant held means the muxed stream moved without an owner
    a_no_beat_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        !(state_q == IDLE && beat_fire_i));

endmodule

// File: tb/tb_router_wrr_packet_scheduler.sv
// tb_router_wrr_packet_scheduler: directed checks of grant order, weights, hold, watchdog, reset
module tb_router_wrr_packet_scheduler;

    localparam int N  = 10;
    localparam int CW = $clog2(N);
    localparam int W  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*W-1:0] cfg;
    logic          fire;
    logic          last;
    logic [N-1:0]  grant;
    logic [CW-1:0] gidx;
    logic          gvalid;
    logic          err;

    int checks = 0;
    int errors = 0;

    router_wrr_packet_scheduler #(
        .CHANNEL_NUMBER  (N),
        .WEIGHT_WIDTH    (W),
        .MAX_PACKET_BEATS(8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .cfg_weight_i  (cfg),
        .beat_fire_i   (fire),
        .last_i        (last),
        .grant_o       (grant),
        .grant_idx_o   (gidx),
        .grant_valid_o (gvalid),
        .err_long_pkt_o(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input int idx, input logic valid);
        logic [N-1:0] oh;
        oh = valid ? (N'(1) << idx) : '0;
        chk({tag, ".grant"}, 32'(grant), 32'(oh));
        chk({tag, ".idx"}, 32'(gidx), valid ? 32'(idx) : 32'd0);
        chk({tag, ".valid"}, 32'(gvalid), 32'(valid));
    endtask

    task automatic do_reset();
        rst = 1'b1; fire = 1'b0; last = 1'b0; req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int exp_seq[7];
        cfg = {N{3'd1}};
        do_reset();

        // 1) idle after reset, then single requester granted one cycle later
        for (int i = 0; i < 10; i++) begin
            step();
            chk_grant("idle", 0, 1'b0);
            chk("idle.err", 32'(err), 32'd0);
        end
        req = 10'b0000000100;
        chk_grant("same_cycle", 0, 1'b0);
        step();
        chk_grant("first", 2, 1'b1);
        fire = 1'b1; last = 1'b1; req = '0;
        step();
        fire = 1'b0; last = 1'b0;
        chk_grant("first_end", 0, 1'b0);

        // 2) equal weights, all requesting, 1-beat packets: 0..9 then 0 with no bubble
        do_reset();
        req = '1;
        step();
        chk_grant("rr0", 0, 1'b1);
        fire = 1'b1; last = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk_grant($sformatf("rr%0d", i), i % N, 1'b1);
        end
        req = '0;
        step();
        fire = 1'b0; last = 1'b0;
        chk_grant("rr_end", 0, 1'b0);

        // 3) weight 3 on ch0, weight 1 on ch1: 0,0,0,1,0,0,0,1
        do_reset();
        cfg[2:0] = 3'd3;
        req = 10'b11;
        step();
        chk_grant("wrr0", 0, 1'b1);
        exp_seq = '{0, 0, 1, 0, 0, 0, 1};
        fire = 1'b1; last = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk_grant($sformatf("wrr%0d", i + 1), exp_seq[i], 1'b1);
        end
        req = '0;
        step();
        fire = 1'b0; last = 1'b0;
        chk_grant("wrr_end", 0, 1'b0);
        cfg = {N{3'd1}};

        // 4) ch4 holds through a 5-beat packet while its TVALID drops, then ch5
        do_reset();
        req = 10'b0000010000;
        step();
        chk_grant("hold_g", 4, 1'b1);
        req = 10'b0000110000; fire = 1'b1; last = 1'b0;
        step();
        chk_grant("hold_b1", 4, 1'b1);
        req = 10'b0000100000;
        step();
        chk_grant("hold_b2", 4, 1'b1);
        fire = 1'b0;
        step();
        chk_grant("hold_gap", 4, 1'b1);
        fire = 1'b1;
        step();
        chk_grant("hold_b3", 4, 1'b1);
        req = 10'b0000110000;
        step();
        chk_grant("hold_b4", 4, 1'b1);
        last = 1'b1;
        step();
        chk_grant("hold_next", 5, 1'b1);
        chk("hold.err", 32'(err), 32'd0);
        req = '0;
        step();
        fire = 1'b0; last = 1'b0;
        chk_grant("hold_end", 0, 1'b0);

        // 5) 9-beat packet trips the watchdog on beat 8; sticky until reset
        do_reset();
        req = 10'b1;
        step();
        chk_grant("wd_g", 0, 1'b1);
        fire = 1'b1; last = 1'b0;
        for (int i = 1; i <= 7; i++) step();
        chk("wd.beat7", 32'(err), 32'd0);
        step();
        chk("wd.beat8", 32'(err), 32'd1);
        last = 1'b1; req = '0;
        step();
        fire = 1'b0; last = 1'b0;
        chk_grant("wd_end", 0, 1'b0);
        step();
        step();
        chk("wd.sticky", 32'(err), 32'd1);
        req = 10'b0000001000;
        step();
        chk_grant("rst_g", 3, 1'b1);
        fire = 1'b1;
        step();
        step();
        rst = 1'b1; fire = 1'b0;
        step();
        rst = 1'b0; req = 10'b0000100001;
        chk_grant("rst_drop", 0, 1'b0);
        chk("rst.err", 32'(err), 32'd0);
        step();
        chk_grant("rst_ptr", 0, 1'b1);
        fire = 1'b1; last = 1'b1; req = '0;
        step();
        fire = 1'b0; last = 1'b0;
        chk_grant("rst_end", 0, 1'b0);

        // 6) lone requester ch7 is re-granted packet after packet without a bubble
        do_reset();
        req = 10'b0010000000;
        step();
        chk_grant("solo0", 7, 1'b1);
        fire = 1'b1; last = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            chk_grant($sformatf("solo%0d", i), 7, 1'b1);
        end
        req = '0;
        step();
        fire = 1'b0; last = 1'b0;
        chk_grant("solo_end", 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
